// File: rtl/box_update_ctrl_pkg.sv
// Shared types and defaults for the overlay box update controller.
package box_update_ctrl_pkg;

  localparam int IMG_WIDTH_DEF  = 768;
  localparam int IMG_HEIGHT_DEF = 576;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_PEND  = 2'd2
  } state_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t w;
    coord_t h;
  } box_t;

endpackage

// File: rtl/box_clamp.sv
// Combinational clamp that shrinks a centred box so it stays inside the image.
import box_update_ctrl_pkg::*;

module box_clamp #(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  box_t box_in,
  output box_t box_out
);

  localparam logic [11:0] W_M1 = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] H_M1 = 12'(IMG_HEIGHT - 1);

  // Left/top edge first, then right/bottom edge on the already shrunk size.
  // Out-of-range centres produce garbage here but are rejected upstream.
  function automatic coord_t clamp_axis(input coord_t c, input coord_t s,
                                        input logic [11:0] lim_m1);
    logic [11:0] pos;
    logic [11:0] sz;
    logic [11:0] half;
    pos = {1'b0, c};
    sz  = {1'b0, s};
    if ({2'b00, s[10:1]} > pos) sz = pos << 1;
    half = sz >> 1;
    if (pos + half > lim_m1) sz = (lim_m1 - pos) << 1;
    return sz[10:0];
  endfunction

  always_comb begin
    box_out   = box_in;
    box_out.w = clamp_axis(box_in.x, box_in.w, W_M1);
    box_out.h = clamp_axis(box_in.y, box_in.h, H_M1);
  end

endmodule

// File: rtl/box_update_ctrl.sv
// Accepts detector boxes, validates them and commits them to the overlay on frame_start.
// Optional BOX_CLAMP_EN shrinks accepted boxes so they never wrap past the image edge.
import box_update_ctrl_pkg::*;

module box_update_ctrl #(
  parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF,
  parameter int HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [10:0] det_x,
  input  logic [10:0] det_y,
  input  logic [10:0] det_w,
  input  logic [10:0] det_h,
  input  logic        det_valid,
  output logic        det_ready,
  output logic [10:0] box_x,
  output logic [10:0] box_y,
  output logic [10:0] box_width,
  output logic [10:0] box_height,
  output logic        box_en,
  output logic        commit,
  output logic [7:0]  drop_cnt,
  output state_t      fsm_state
);

  localparam coord_t     W_C    = coord_t'(IMG_WIDTH);
  localparam coord_t     H_C    = coord_t'(IMG_HEIGHT);
  localparam logic [7:0] HOLD_C = 8'(HOLD_FRAMES);

  // Handshake: a detection transfers on a rising clk edge where det_valid
  // and det_ready are both high; det_ready is high only while idle, so a
  // pending box can never be overwritten.

  state_t     state, state_nxt;
  box_t       shadow, shadow_nxt, checked, box_q;
  logic       reject, do_commit;
  logic [7:0] age, age_inc;

`ifdef BOX_CLAMP_EN
  box_clamp #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_box_clamp (
    .box_in (shadow),
    .box_out(checked)
  );
`else
  assign checked = shadow;
`endif

  assign reject    = (checked.w == '0) || (checked.h == '0) ||
                     (shadow.x >= W_C) || (shadow.y >= H_C);
  assign do_commit = (state == ST_PEND) && frame_start;
  assign age_inc   = (age == 8'hFF) ? age : age + 8'd1;

  assign det_ready  = (state == ST_IDLE);
  assign fsm_state  = state;
  assign box_x      = box_q.x;
  assign box_y      = box_q.y;
  assign box_width  = box_q.w;
  assign box_height = box_q.h;

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    case (state)
      ST_IDLE: begin
        if (det_valid) begin
          shadow_nxt = '{x: det_x, y: det_y, w: det_w, h: det_h};
          state_nxt  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (reject) begin
          state_nxt = ST_IDLE;
        end else begin
          shadow_nxt = checked;
          state_nxt  = ST_PEND;
        end
      end
      ST_PEND: begin
        if (frame_start) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      shadow   <= '0;
      box_q    <= '0;
      box_en   <= 1'b0;
      commit   <= 1'b0;
      drop_cnt <= 8'd0;
      age      <= 8'd0;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
      commit <= do_commit;
      if (do_commit) begin
        box_q  <= shadow;
        box_en <= 1'b1;
        age    <= 8'd0;
      end else if (frame_start) begin
        age <= age_inc;
        if (age_inc >= HOLD_C) box_en <= 1'b0;
      end
      if ((state == ST_CHECK) && reject && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_box_update_ctrl.sv
// Self-checking bench for box_update_ctrl: directed vector table, hand sequences, random vs model.
module tb_box_update_ctrl;
  import box_update_ctrl_pkg::*;

  localparam int W    = 768;
  localparam int H    = 576;
  localparam int HOLD = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        det_valid = 1'b0;
  logic [10:0] det_x = '0, det_y = '0, det_w = '0, det_h = '0;
  logic        det_ready, box_en, commit;
  logic [10:0] box_x, box_y, box_width, box_height;
  logic [7:0]  drop_cnt;
  state_t      fsm_state;

  box_update_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .HOLD_FRAMES(HOLD)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .det_x(det_x), .det_y(det_y), .det_w(det_w), .det_h(det_h),
    .det_valid(det_valid), .det_ready(det_ready),
    .box_x(box_x), .box_y(box_y), .box_width(box_width), .box_height(box_height),
    .box_en(box_en), .commit(commit), .drop_cnt(drop_cnt), .fsm_state(fsm_state)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: tracks edge numbers at which things become possible.
  int m_n = 0, m_ready_edge = 0, m_commit_from = 0, m_drop_at = -1;
  bit m_pending = 0, m_en = 0, m_commit = 0;
  int m_age = 0, m_drop = 0;
  int m_bx = 0, m_by = 0, m_bw = 0, m_bh = 0;
  int s_x = 0, s_y = 0, s_w = 0, s_h = 0;
  logic [10:0] exp_q[$];

  function automatic int clamp_size(input int c, input int s, input int lim);
    int r;
    r = s;
`ifdef BOX_CLAMP_EN
    if (r / 2 > c) r = 2 * c;
    if (c + r / 2 > lim - 1) r = 2 * (lim - 1 - c);
`endif
    return r;
  endfunction

  task automatic model_edge();
    bit ready_now;
    int cw, ch;
    m_n++;
    if (!reset) begin
      m_pending = 0; m_ready_edge = 0; m_drop_at = -1;
      m_bx = 0; m_by = 0; m_bw = 0; m_bh = 0;
      m_en = 0; m_commit = 0; m_drop = 0; m_age = 0;
    end else begin
      ready_now = !m_pending && (m_n >= m_ready_edge);
      m_commit = 0;
      if (m_drop_at == m_n && m_drop < 255) m_drop++;
      if (m_pending && frame_start && m_n >= m_commit_from) begin
        m_bx = s_x; m_by = s_y; m_bw = s_w; m_bh = s_h;
        m_commit = 1; m_en = 1; m_age = 0;
        m_pending = 0; m_ready_edge = m_n + 1;
        exp_q.push_back(11'(s_w));
      end else if (frame_start) begin
        if (m_age < 255) m_age++;
        if (m_age >= HOLD) m_en = 0;
      end
      if (ready_now && det_valid) begin
        cw = clamp_size(int'(det_x), int'(det_w), W);
        ch = clamp_size(int'(det_y), int'(det_h), H);
        if (cw == 0 || ch == 0 || det_x >= W || det_y >= H) begin
          m_drop_at = m_n + 1; m_ready_edge = m_n + 2;
        end else begin
          m_pending = 1; m_commit_from = m_n + 2;
          s_x = det_x; s_y = det_y; s_w = cw; s_h = ch;
        end
      end
    end
  endtask

  // driver
  task automatic drive(input logic r, input logic fs, input logic dv,
                       input int x, input int y, input int w, input int h);
    reset = r; frame_start = fs; det_valid = dv;
    det_x = 11'(x); det_y = 11'(y); det_w = 11'(w); det_h = 11'(h);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(); drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0); endtask

  task automatic check_model(input string tag);
    chk({tag, "_ready"},  int'(det_ready),  int'(!m_pending && (m_n + 1 >= m_ready_edge)));
    chk({tag, "_commit"}, int'(commit),     int'(m_commit));
    chk({tag, "_en"},     int'(box_en),     int'(m_en));
    chk({tag, "_x"},      int'(box_x),      m_bx);
    chk({tag, "_y"},      int'(box_y),      m_by);
    chk({tag, "_w"},      int'(box_width),  m_bw);
    chk({tag, "_h"},      int'(box_height), m_bh);
    chk({tag, "_drop"},   int'(drop_cnt),   m_drop);
    if (commit) begin
      if (exp_q.size() == 0) chk({tag, "_commit_q_empty"}, 1, 0);
      else chk({tag, "_commit_w_q"}, int'(box_width), int'(exp_q.pop_front()));
    end
  endtask

  typedef struct {
    logic rst, fs, dv;
    int   x, y, w, h;
    logic e_ready, e_commit, e_en;
    int   e_bx, e_bw, e_bh, e_drop;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic fs, input logic dv,
                              input int x, input int y, input int w, input int h,
                              input logic er, input logic ec, input logic ee,
                              input int ebx, input int ebw, input int ebh, input int ed);
    vec_t v;
    v.rst = rst; v.fs = fs; v.dv = dv; v.x = x; v.y = y; v.w = w; v.h = h;
    v.e_ready = er; v.e_commit = ec; v.e_en = ee;
    v.e_bx = ebx; v.e_bw = ebw; v.e_bh = ebh; v.e_drop = ed;
    return v;
  endfunction

  vec_t vecs[24];

  initial begin
    int cw;
    int dv_pct;
    bit any_commit;
`ifdef BOX_CLAMP_EN
    cw = 20;
`else
    cw = 100;
`endif
    //               rst fs dv   x    y    w    h   rdy cm en  bx   bw   bh drop
    vecs[0]  = mk(0, 0, 0,   0,   0,   0,   0,  1, 0, 0,   0,   0,  0, 0);
    vecs[1]  = mk(1, 0, 0,   0,   0,   0,   0,  1, 0, 0,   0,   0,  0, 0);
    vecs[2]  = mk(1, 0, 1, 384, 288, 100,  80,  0, 0, 0,   0,   0,  0, 0);
    vecs[3]  = mk(1, 0, 0,   0,   0,   0,   0,  0, 0, 0,   0,   0,  0, 0);
    vecs[4]  = mk(1, 0, 0,   0,   0,   0,   0,  0, 0, 0,   0,   0,  0, 0);
    vecs[5]  = mk(1, 1, 0,   0,   0,   0,   0,  1, 1, 1, 384, 100, 80, 0);
    vecs[6]  = mk(1, 0, 0,   0,   0,   0,   0,  1, 0, 1, 384, 100, 80, 0);
    vecs[7]  = mk(1, 1, 1, 200, 100,  50,  40,  0, 0, 1, 384, 100, 80, 0);
    vecs[8]  = mk(1, 1, 0,   0,   0,   0,   0,  0, 0, 1, 384, 100, 80, 0);
    vecs[9]  = mk(1, 0, 0,   0,   0,   0,   0,  0, 0, 1, 384, 100, 80, 0);
    vecs[10] = mk(1, 1, 0,   0,   0,   0,   0,  1, 1, 1, 200,  50, 40, 0);
    vecs[11] = mk(1, 0, 0,   0,   0,   0,   0,  1, 0, 1, 200,  50, 40, 0);
    vecs[12] = mk(1, 0, 1, 100, 100,   0,  10,  0, 0, 1, 200,  50, 40, 0);
    vecs[13] = mk(1, 0, 0,   0,   0,   0,   0,  1, 0, 1, 200,  50, 40, 1);
    vecs[14] = mk(1, 0, 1, 800, 100,  20,  20,  0, 0, 1, 200,  50, 40, 1);
    vecs[15] = mk(1, 0, 0,   0,   0,   0,   0,  1, 0, 1, 200,  50, 40, 2);
    vecs[16] = mk(1, 1, 0,   0,   0,   0,   0,  1, 0, 1, 200,  50, 40, 2);
    vecs[17] = mk(1, 0, 1,  10, 288, 100,  80,  0, 0, 1, 200,  50, 40, 2);
    vecs[18] = mk(1, 0, 0,   0,   0,   0,   0,  0, 0, 1, 200,  50, 40, 2);
    vecs[19] = mk(1, 1, 0,   0,   0,   0,   0,  1, 1, 1,  10,  cw, 80, 2);
    vecs[20] = mk(1, 0, 1, 300, 300,  30,  30,  0, 0, 1,  10,  cw, 80, 2);
    vecs[21] = mk(1, 0, 0,   0,   0,   0,   0,  0, 0, 1,  10,  cw, 80, 2);
    vecs[22] = mk(0, 0, 0,   0,   0,   0,   0,  1, 0, 0,   0,   0,  0, 0);
    vecs[23] = mk(1, 1, 0,   0,   0,   0,   0,  1, 0, 0,   0,   0,  0, 0);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rst, vecs[i].fs, vecs[i].dv, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h);
      chk($sformatf("v%0d_ready", i),  int'(det_ready),  int'(vecs[i].e_ready));
      chk($sformatf("v%0d_commit", i), int'(commit),     int'(vecs[i].e_commit));
      chk($sformatf("v%0d_en", i),     int'(box_en),     int'(vecs[i].e_en));
      chk($sformatf("v%0d_bx", i),     int'(box_x),      vecs[i].e_bx);
      chk($sformatf("v%0d_bw", i),     int'(box_width),  vecs[i].e_bw);
      chk($sformatf("v%0d_bh", i),     int'(box_height), vecs[i].e_bh);
      chk($sformatf("v%0d_drop", i),   int'(drop_cnt),   vecs[i].e_drop);
    end

    // hold expiry: box_en falls on the 8th frame without a detection
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b1, 384, 288, 100, 80);
    idle(); idle();
    drive(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
    chk("hold_commit", int'(commit), 1);
    for (int i = 1; i <= 8; i++) begin
      idle();
      drive(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
      chk($sformatf("hold_en_f%0d", i), int'(box_en), (i < 8) ? 1 : 0);
      chk($sformatf("hold_bw_f%0d", i), int'(box_width), 100);
      chk($sformatf("hold_bx_f%0d", i), int'(box_x), 384);
      chk($sformatf("hold_commit_f%0d", i), int'(commit), 0);
    end

    // drop counter saturation
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    any_commit = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, (i % 3) == 0, 1'b1, 100, 100, 0, 10);
      any_commit |= commit;
      idle();
      any_commit |= commit;
      if (i == 254) chk("drop_at_255", int'(drop_cnt), 255);
    end
    chk("drop_sat_300", int'(drop_cnt), 255);
    chk("drop_no_commit", int'(any_commit), 0);

    // randomized run against the model
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    exp_q.delete();
    for (int i = 0; i < 4000; i++) begin
      case ((i / 500) % 4)
        0: dv_pct = 50;
        1: dv_pct = 5;
        2: dv_pct = 0;
        default: dv_pct = 80;
      endcase
      drive(($urandom_range(0, 499) != 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 99) < dv_pct),
            $urandom_range(0, 900), $urandom_range(0, 700),
            ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300),
            ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300));
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
